// File: rtl/ccff_pkg.sv
// ccff_pkg
// Shared definitions for the configuration-chain loader:
//   - state_e        : loader FSM states (IDLE/LOAD/SHIFT/DONE)
//   - DEFAULT_WORD_W : default bitstream word width
//   - cnt_width()    : width needed to hold the values 0..n inclusive
package ccff_pkg;

    localparam int DEFAULT_WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Counter width able to represent 0..n inclusive (never below 1 bit).
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ccff_readback_collector.sv
// ccff_readback_collector
// Samples ccff_tail on every chain shift and packs the bits into readback
// words. The first captured bit lands in the MSB. A word is flushed when it
// is full or when the final chain bit has been taken; a short final word is
// left-justified.
// Ports:
//   clk_i      : configuration clock (prog_clk)
//   rst_ni     : synchronous active-low reset
//   clear_i    : drop any partial word without flushing (abort)
//   shift_i    : chain advances on this edge, sample tail_i
//   last_i     : this shift carries the last chain bit
//   tail_i     : serial data from the chain tail
//   rb_word_o  : readback word
//   rb_valid_o : one-cycle pulse, rb_word_o updated
module ccff_readback_collector
    import ccff_pkg::*;
#(
    parameter int WORD_W = DEFAULT_WORD_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic              last_i,
    input  logic              tail_i,
    output logic [WORD_W-1:0] rb_word_o,
    output logic              rb_valid_o
);

    localparam int RC_W = cnt_width(WORD_W);
    localparam logic [RC_W-1:0] FULL_CNT = RC_W'(WORD_W);

    logic [WORD_W-1:0] sreg_q;
    logic [RC_W-1:0]   cnt_q;
    logic [WORD_W-1:0] word_q;
    logic              valid_q;

    logic [WORD_W-1:0] sreg_d;
    logic [RC_W-1:0]   cnt_d;
    logic              flush;
    logic [WORD_W-1:0] justified;

    always_comb begin
        sreg_d    = {sreg_q[WORD_W-2:0], tail_i};
        cnt_d     = cnt_q + RC_W'(1);
        flush     = (cnt_d == FULL_CNT) || last_i;
        // Short final word: move the captured bits up to the MSB end.
        justified = sreg_d << (FULL_CNT - cnt_d);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sreg_q  <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            // Partial data is discarded; the last delivered word stays visible.
            sreg_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (shift_i) begin
                if (flush) begin
                    word_q  <= justified;
                    valid_q <= 1'b1;
                    sreg_q  <= '0;
                    cnt_q   <= '0;
                end else begin
                    sreg_q <= sreg_d;
                    cnt_q  <= cnt_d;
                end
            end
        end
    end

    assign rb_word_o  = word_q;
    assign rb_valid_o = valid_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
// Upstream driver for a DFF configuration chain. Takes bitstream words over a
// valid/ready stream and shifts exactly CHAIN_LEN bits, MSB first, onto
// ccff_head while ccff_shift_en gates the chain clock. The previous chain
// contents emerging on ccff_tail are packed into readback words.
// Ports:
//   prog_clk, prog_rst_n        : clock, synchronous active-low reset
//   start, abort                : begin a load (IDLE only) / return to IDLE
//   cfg_word, cfg_valid, cfg_ready : bitstream word stream
//   ccff_head, ccff_shift_en    : serial data and advance enable to the chain
//   ccff_tail                   : serial data from the chain tail
//   rb_word, rb_valid           : readback words
//   busy, done                  : LOAD/SHIFT indicator, end-of-load pulse
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int WORD_W    = DEFAULT_WORD_W,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_word,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rb_word,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);

    localparam int WB_W = cnt_width(WORD_W);

    if (CHAIN_LEN < 1) begin : g_bad_chain_len
        $error("ccff_chain_loader: CHAIN_LEN must be at least 1");
    end
    if (WORD_W < 2) begin : g_bad_word_w
        $error("ccff_chain_loader: WORD_W must be at least 2");
    end

    state_e            state_q;
    logic [WORD_W-1:0] sreg_q;
    logic [WB_W-1:0]   wbits_q;
    logic [CNT_W-1:0]  remaining_q;

    logic [31:0]       rem_ext;
    logic [WB_W-1:0]   wbits_d;
    logic              last_bit;

    // Bits taken from the next word: a full word, or only the top
    // `remaining` bits of the final partial word.
    assign rem_ext  = 32'(remaining_q);
    assign wbits_d  = (rem_ext >= 32'(WORD_W)) ? WB_W'(WORD_W) : WB_W'(rem_ext);
    assign last_bit = (state_q == ST_SHIFT) && (remaining_q == CNT_W'(1));

    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n || abort) begin
            // Abort outranks start and cfg_valid; the chain is left as-is.
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            wbits_q     <= '0;
            remaining_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        remaining_q <= CNT_W'(CHAIN_LEN);
                        state_q     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (cfg_valid) begin
                        sreg_q  <= cfg_word;
                        wbits_q <= wbits_d;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sreg_q      <= {sreg_q[WORD_W-2:0], 1'b0};
                    wbits_q     <= wbits_q - WB_W'(1);
                    remaining_q <= remaining_q - CNT_W'(1);
                    if (wbits_q == WB_W'(1)) begin
                        state_q <= (remaining_q == CNT_W'(1)) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode the state register only, so they change on clock edges.
    assign cfg_ready     = (state_q == ST_LOAD);
    assign ccff_shift_en = (state_q == ST_SHIFT);
    assign ccff_head     = ccff_shift_en & sreg_q[WORD_W-1];
    assign busy          = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
    assign done          = (state_q == ST_DONE);

    ccff_readback_collector #(
        .WORD_W (WORD_W)
    ) u_readback (
        .clk_i      (prog_clk),
        .rst_ni     (prog_rst_n),
        .clear_i    (abort),
        .shift_i    (ccff_shift_en),
        .last_i     (last_bit),
        .tail_i     (ccff_tail),
        .rb_word_o  (rb_word),
        .rb_valid_o (rb_valid)
    );

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] cfg_word = 4'h0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic       head;
    logic       shift_en;
    logic       tail;
    logic [3:0] rb_word;
    logic       rb_valid;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    ccff_chain_loader #(
        .WORD_W    (4),
        .CHAIN_LEN (5)
    ) dut (
        .prog_clk      (clk),
        .prog_rst_n    (rst_n),
        .start         (start),
        .abort         (abort),
        .cfg_word      (cfg_word),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .ccff_head     (head),
        .ccff_shift_en (shift_en),
        .ccff_tail     (tail),
        .rb_word       (rb_word),
        .rb_valid      (rb_valid),
        .busy          (busy),
        .done          (done)
    );

    // 5-DFF chain model: bit i is mem_out[i]; head enters bit 0, tail is bit 4.
    logic [4:0] chain;
    logic       preload_en = 1'b0;
    logic [4:0] preload_val = 5'b0;

    always @(posedge clk) begin
        if (preload_en)    chain <= preload_val;
        else if (shift_en) chain <= {chain[3:0], head};
    end
    assign tail = chain[4];

    // Negedge monitor of per-load activity.
    logic       mon_clr = 1'b0;
    int         cyc = 0;
    int         shift_cnt, done_cnt, rb_n, first_sh, last_sh;
    logic [4:0] heads;
    logic [3:0] rb_w [0:3];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mon_clr) begin
            shift_cnt = 0; done_cnt = 0; rb_n = 0;
            first_sh = -1; last_sh = -1; heads = 5'b0;
        end else begin
            if (shift_en) begin
                shift_cnt = shift_cnt + 1;
                heads = {heads[3:0], head};
                if (first_sh < 0) first_sh = cyc;
                last_sh = cyc;
            end
            if (done) done_cnt = done_cnt + 1;
            if (rb_valid) begin
                if (rb_n < 4) rb_w[rb_n] = rb_word;
                rb_n = rb_n + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
    endtask

    task automatic preload(input logic [4:0] v);
        preload_en  = 1'b1;
        preload_val = v;
        step();
        preload_en  = 1'b0;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!cfg_ready && t < 50) begin
            step();
            t++;
        end
    endtask

    // Start a load, optionally stall before the first word and poke start
    // during SHIFT, then wait (bounded) for completion.
    task automatic do_load(input logic [3:0] w0, input logic [3:0] w1,
                           input int stall, input bit poke_start);
        logic [4:0] chain_before;
        int t;
        clear_mon();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_ready();
        if (stall > 0) begin
            chain_before = chain;
            repeat (stall) step();
            check("stall_shift_cnt", shift_cnt, 0);
            check("stall_ready", {31'b0, cfg_ready}, 1);
            check("stall_chain", {27'b0, chain}, {27'b0, chain_before});
        end
        cfg_valid = 1'b1; cfg_word = w0;
        step();
        cfg_valid = 1'b0;
        if (poke_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        wait_ready();
        cfg_valid = 1'b1; cfg_word = w1;
        step();
        cfg_valid = 1'b0;
        t = 0;
        while (done_cnt == 0 && t < 40) begin
            step();
            t++;
        end
        step();
        step();
        $display("load %h,%h: shifts=%0d heads=%b done=%0d rb_n=%0d chain=%b",
                 w0, w1, shift_cnt, heads, done_cnt, rb_n, chain);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) step();
        check("reset_outs", {26'b0, cfg_ready, head, shift_en, rb_valid, busy, done}, 0);
        check("reset_rb_word", {28'b0, rb_word}, 0);
        rst_n = 1'b1;
        step();

        // Basic load into a cleared chain: A then C
        preload(5'b00000);
        do_load(4'hA, 4'hC, 0, 1'b0);
        check("t1_heads", {27'b0, heads}, 5'b10101);
        check("t1_shift_cnt", shift_cnt, 5);
        check("t1_shift_span", last_sh - first_sh + 1, 6);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_rb_cnt", rb_n, 2);
        check("t1_rb0", {28'b0, rb_w[0]}, 4'h0);
        check("t1_chain", {27'b0, chain}, 5'b10101);
        check("t1_idle", {30'b0, busy, shift_en}, 0);

        // Readback of a chain preloaded with all ones
        preload(5'b11111);
        do_load(4'hA, 4'hC, 0, 1'b0);
        check("t2_rb_cnt", rb_n, 2);
        check("t2_rb0", {28'b0, rb_w[0]}, 4'hF);
        check("t2_rb1", {28'b0, rb_w[1]}, 4'h8);
        check("t2_chain", {27'b0, chain}, 5'b10101);

        // Stall 10 cycles in LOAD; partial final word 0x7 uses only its MSB
        do_load(4'h5, 4'h7, 10, 1'b0);
        check("t3_heads", {27'b0, heads}, 5'b01010);
        check("t3_shift_cnt", shift_cnt, 5);
        check("t3_done_cnt", done_cnt, 1);
        check("t3_rb0", {28'b0, rb_w[0]}, 4'hA);
        check("t3_rb1", {28'b0, rb_w[1]}, 4'h8);
        check("t3_chain", {27'b0, chain}, 5'b01010);

        // Abort during the second shift cycle
        clear_mon();
        start = 1'b1; step(); start = 1'b0;
        wait_ready();
        cfg_valid = 1'b1; cfg_word = 4'hF; step(); cfg_valid = 1'b0;
        step();
        abort = 1'b1; step(); abort = 1'b0;
        check("t4_after_abort", {30'b0, busy, shift_en}, 0);
        repeat (4) step();
        $display("abort: shifts=%0d done=%0d rb_n=%0d chain=%b", shift_cnt, done_cnt, rb_n, chain);
        check("t4_shift_cnt", shift_cnt, 2);
        check("t4_done_cnt", done_cnt, 0);
        check("t4_rb_cnt", rb_n, 0);
        check("t4_chain", {27'b0, chain}, 5'b01011);

        // Abort outranks cfg_valid in LOAD and start in IDLE
        clear_mon();
        start = 1'b1; step(); start = 1'b0;
        cfg_valid = 1'b1; cfg_word = 4'hF; abort = 1'b1;
        step();
        cfg_valid = 1'b0; abort = 1'b0;
        check("t5_abort_vs_valid", {29'b0, busy, shift_en, cfg_ready}, 0);
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("t5_abort_vs_start", {31'b0, busy}, 0);
        repeat (3) step();
        check("t5_shift_cnt", shift_cnt, 0);

        // Reset in the middle of SHIFT, then a full load afterwards
        clear_mon();
        start = 1'b1; step(); start = 1'b0;
        wait_ready();
        cfg_valid = 1'b1; cfg_word = 4'hF; step(); cfg_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        check("t6_reset_outs", {26'b0, cfg_ready, head, shift_en, rb_valid, busy, done}, 0);
        check("t6_reset_rb_word", {28'b0, rb_word}, 0);
        rst_n = 1'b1;
        preload(5'b10011);
        do_load(4'hA, 4'hC, 0, 1'b0);
        check("t6_heads", {27'b0, heads}, 5'b10101);
        check("t6_shift_cnt", shift_cnt, 5);
        check("t6_done_cnt", done_cnt, 1);
        check("t6_rb0", {28'b0, rb_w[0]}, 4'h9);
        check("t6_rb1", {28'b0, rb_w[1]}, 4'h8);

        // start pulsed during SHIFT is ignored
        do_load(4'h3, 4'h8, 0, 1'b1);
        check("t7_heads", {27'b0, heads}, 5'b00111);
        check("t7_shift_cnt", shift_cnt, 5);
        check("t7_done_cnt", done_cnt, 1);
        check("t7_rb0", {28'b0, rb_w[0]}, 4'hA);
        check("t7_chain", {27'b0, chain}, 5'b00111);
        repeat (3) step();
        check("t7_idle", {31'b0, busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
